rsa_mac_array: RTL and testbench

Parametrised output-stationary systolic MAC array. It computes C = A·B (optionally C += A·B) over a runtime inner dimension of 1..L, then drains the X×Y result one row per beat through a valid/ready handshake. It sits where the EKF datapath needs matrix products. Over the previous array generation it adds:
- internal input skewing;
- per-PE accumulators with saturation;
- a run controller FSM;
- runtime flow-direction selection;
- back-pressured result drain.

---
 rtl/rsa_pkg.sv | 18 +
 rtl/pe_mac_acc.sv | 64 ++++++
 rtl/rsa_mac_array.sv | 273 +++++++++++++++++++++++++++
 tb/tb_rsa_mac_array.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the rsa_mac_array systolic MAC block:
// flow-direction encodings and the run-controller state type.
package rsa_pkg;

    // dir[0] selects the A flow, dir[1] selects the B flow.
    localparam logic W_2_E = 1'b0;
    localparam logic E_2_W = 1'b1;
    localparam logic N_2_S = 1'b0;
    localparam logic S_2_N = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StFlush,
        StDrain
    } rsa_state_e;

endpackage

// File: rtl/pe_mac_acc.sv
// One systolic processing element: A/B pass-through pipe registers and a
// saturating signed multiply-accumulate, advanced only when en_i is high.
module pe_mac_acc #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 2 * DW + 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [DW-1:0] a_o,
    output logic signed [DW-1:0] b_o,
    output logic signed [AW-1:0] acc_o
);

    localparam logic signed [AW-1:0] AccMax = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] AccMin = {1'b1, {(AW-1){1'b0}}};

    logic signed [DW-1:0]   a_q, a_d, b_q, b_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [2*DW-1:0] a_ext, b_ext, prod;
    logic signed [AW:0]     sum;

    always_comb begin
        a_ext = {{DW{a_i[DW-1]}}, a_i};
        b_ext = {{DW{b_i[DW-1]}}, b_i};
        prod  = a_ext * b_ext;
        // One guard bit: overflow shows up as disagreement of the top two bits.
        sum   = {acc_q[AW-1], acc_q} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            a_d = a_i;
            b_d = b_i;
            if (sum[AW] != sum[AW-1]) begin
                acc_d = sum[AW] ? AccMin : AccMax;
            end else begin
                acc_d = sum[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/rsa_mac_array.sv
// Output-stationary X-by-Y systolic MAC array with input skewing, runtime flow
// direction, a feed/flush/drain run controller and a back-pressured row drain.
module rsa_mac_array
    import rsa_pkg::*;
#(
    parameter int unsigned X      = 4,
    parameter int unsigned Y      = 4,
    parameter int unsigned L      = 4,
    parameter int unsigned RSA_DW = 16,
    parameter int unsigned ACC_DW = 2 * RSA_DW + 4,
    parameter int unsigned FRAC   = 0
) (
    input  logic                                  clk,
    input  logic                                  sys_rst,
    input  logic                                  start,
    input  logic [$clog2(L+1)-1:0]                len,
    input  logic [1:0]                            dir,
    input  logic                                  accumulate,
    input  logic [X*RSA_DW-1:0]                   A_data,
    input  logic [Y*RSA_DW-1:0]                   B_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [Y*RSA_DW-1:0]                   C_data,
    output logic [((X > 1) ? $clog2(X) : 1)-1:0]  C_row,
    output logic                                  C_valid,
    input  logic                                  C_ready,
    output logic                                  busy,
    output logic                                  err
);

    localparam int unsigned DW = RSA_DW;
    localparam int unsigned LW = $clog2(L + 1);
    localparam int unsigned RW = (X > 1) ? $clog2(X) : 1;
    localparam int unsigned CW = $clog2(L + X + Y + 1);

    localparam logic signed [ACC_DW-1:0] OutMax = {{(ACC_DW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_DW-1:0] OutMin = {{(ACC_DW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    rsa_state_e    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RW-1:0] row_q, row_d;
    logic          err_q, err_d;
    logic          step, clr;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        err_d   = 1'b0;
        step    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len == '0 || len > LW'(L)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StFeed;
                        len_d   = len;
                        dir_d   = dir;
                        cnt_d   = '0;
                        clr     = ~accumulate;
                    end
                end
            end
            StFeed: begin
                if (in_valid) begin
                    step  = 1'b1;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(len_q)) begin
                        state_d = StFlush;
                        cnt_d   = '0;
                    end
                end
            end
            StFlush: begin
                step  = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_q == CW'(X + Y - 2)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            StDrain: begin
                if (C_ready) begin
                    row_d = row_q + RW'(1);
                    if (row_q == RW'(X - 1)) begin
                        state_d = StIdle;
                        row_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            dir_q   <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    logic signed [DW-1:0] edge_a [X];
    logic signed [DW-1:0] edge_b [Y];

    // A row delay equals the B travel distance to that row, and vice versa, so
    // operands meet whichever way each stream flows. Zeros are injected in FLUSH.
    for (genvar i = 0; i < X; i++) begin : g_a_skew
        localparam int unsigned DN = i;
        localparam int unsigned DS = X - 1 - i;
        localparam int unsigned DM = (DN > DS) ? DN : DS;
        logic signed [DW-1:0] lane, tap_n, tap_s;
        assign lane = (state_q == StFeed) ? A_data[i*DW +: DW] : '0;
        if (DM > 0) begin : g_sr
            logic signed [DW-1:0] sr_q [DM];
            logic signed [DW-1:0] sr_d [DM];
            always_comb begin
                sr_d[0] = lane;
                for (int k = 1; k < int'(DM); k++) sr_d[k] = sr_q[k-1];
            end
            always_ff @(posedge clk or negedge sys_rst) begin
                if (!sys_rst) begin
                    for (int k = 0; k < int'(DM); k++) sr_q[k] <= '0;
                end else if (step) begin
                    sr_q <= sr_d;
                end
            end
            if (DN == 0) begin : g_n0
                assign tap_n = lane;
            end else begin : g_n
                assign tap_n = sr_q[DN-1];
            end
            if (DS == 0) begin : g_s0
                assign tap_s = lane;
            end else begin : g_s
                assign tap_s = sr_q[DS-1];
            end
        end else begin : g_nosr
            assign tap_n = lane;
            assign tap_s = lane;
        end
        assign edge_a[i] = (dir_q[1] == S_2_N) ? tap_s : tap_n;
    end

    for (genvar j = 0; j < Y; j++) begin : g_b_skew
        localparam int unsigned DW_ = j;
        localparam int unsigned DE  = Y - 1 - j;
        localparam int unsigned DM  = (DW_ > DE) ? DW_ : DE;
        logic signed [DW-1:0] lane, tap_w, tap_e;
        assign lane = (state_q == StFeed) ? B_data[j*DW +: DW] : '0;
        if (DM > 0) begin : g_sr
            logic signed [DW-1:0] sr_q [DM];
            logic signed [DW-1:0] sr_d [DM];
            always_comb begin
                sr_d[0] = lane;
                for (int k = 1; k < int'(DM); k++) sr_d[k] = sr_q[k-1];
            end
            always_ff @(posedge clk or negedge sys_rst) begin
                if (!sys_rst) begin
                    for (int k = 0; k < int'(DM); k++) sr_q[k] <= '0;
                end else if (step) begin
                    sr_q <= sr_d;
                end
            end
            if (DW_ == 0) begin : g_w0
                assign tap_w = lane;
            end else begin : g_w
                assign tap_w = sr_q[DW_-1];
            end
            if (DE == 0) begin : g_e0
                assign tap_e = lane;
            end else begin : g_e
                assign tap_e = sr_q[DE-1];
            end
        end else begin : g_nosr
            assign tap_w = lane;
            assign tap_e = lane;
        end
        assign edge_b[j] = (dir_q[0] == E_2_W) ? tap_e : tap_w;
    end

    logic signed [DW-1:0]     pa   [X][Y];
    logic signed [DW-1:0]     pb   [X][Y];
    logic signed [ACC_DW-1:0] pacc [X][Y];

    for (genvar i = 0; i < X; i++) begin : g_row
        for (genvar j = 0; j < Y; j++) begin : g_col
            logic signed [DW-1:0] a_w, a_e, b_n, b_s, a_src, b_src;
            if (j == 0) begin : g_aw0
                assign a_w = edge_a[i];
            end else begin : g_aw
                assign a_w = pa[i][j-1];
            end
            if (j == Y - 1) begin : g_ae0
                assign a_e = edge_a[i];
            end else begin : g_ae
                assign a_e = pa[i][j+1];
            end
            if (i == 0) begin : g_bn0
                assign b_n = edge_b[j];
            end else begin : g_bn
                assign b_n = pb[i-1][j];
            end
            if (i == X - 1) begin : g_bs0
                assign b_s = edge_b[j];
            end else begin : g_bs
                assign b_s = pb[i+1][j];
            end
            assign a_src = (dir_q[0] == E_2_W) ? a_e : a_w;
            assign b_src = (dir_q[1] == S_2_N) ? b_s : b_n;

            pe_mac_acc #(
                .DW(DW),
                .AW(ACC_DW)
            ) u_pe (
                .clk_i (clk),
                .rst_ni(sys_rst),
                .en_i  (step),
                .clr_i (clr),
                .a_i   (a_src),
                .b_i   (b_src),
                .a_o   (pa[i][j]),
                .b_o   (pb[i][j]),
                .acc_o (pacc[i][j])
            );
        end
    end

    logic signed [ACC_DW-1:0] sh;

    always_comb begin
        C_data = '0;
        sh     = '0;
        if (state_q == StDrain) begin
            for (int j = 0; j < int'(Y); j++) begin
                sh = pacc[row_q][j] >>> FRAC;
                if (sh > OutMax) begin
                    C_data[j*DW +: DW] = OutMax[DW-1:0];
                end else if (sh < OutMin) begin
                    C_data[j*DW +: DW] = OutMin[DW-1:0];
                end else begin
                    C_data[j*DW +: DW] = sh[DW-1:0];
                end
            end
        end
    end

    assign in_ready = (state_q == StFeed);
    assign C_valid  = (state_q == StDrain);
    assign C_row    = row_q;
    assign busy     = (state_q != StIdle);
    assign err      = err_q;

endmodule

// File: tb/tb_rsa_mac_array.sv
// Directed bench for rsa_mac_array (X=Y=L=4, 16-bit operands): identity,
// direction sweep, stalls, saturation, accumulate, rejected start, mid-run reset.
module tb_rsa_mac_array;

    localparam int X = 4;
    localparam int Y = 4;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        sys_rst, start, accumulate, in_valid, in_ready;
    logic        C_valid, C_ready, busy, err;
    logic [2:0]  len;
    logic [1:0]  dir;
    logic [63:0] A_data, B_data, C_data;
    logic [1:0]  C_row;

    always #5 clk = ~clk;

    rsa_mac_array #(
        .X(X), .Y(Y), .L(L), .RSA_DW(16), .ACC_DW(36), .FRAC(0)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .len(len), .dir(dir),
        .accumulate(accumulate), .A_data(A_data), .B_data(B_data),
        .in_valid(in_valid), .in_ready(in_ready), .C_data(C_data), .C_row(C_row),
        .C_valid(C_valid), .C_ready(C_ready), .busy(busy), .err(err)
    );

    int                 n_chk = 0;
    int                 n_pass = 0;
    int                 cyc;
    logic signed [15:0] am [4][4];
    logic signed [15:0] bm [4][4];
    longint             macc [4][4];
    logic [63:0]        got [4];
    logic [63:0]        ref0 [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = 16'(av);
                bm[i][j] = 16'(bv);
            end
    endtask

    // Start pulse with a junk beat alongside: in_ready is low in IDLE, so it must not count.
    task automatic start_run(input int n, input logic [1:0] d, input logic accm, input string tag);
        start = 1'b1; len = 3'(n); dir = d; accumulate = accm;
        in_valid = 1'b1; A_data = '1; B_data = '1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        chk($sformatf("%s_start", tag), {busy, in_ready}, 2'b11);
    endtask

    task automatic feed(input int n, input bit stall_in, output int c);
        int k;
        k = 0; c = 0;
        while (k < n && c < 64) begin
            if (stall_in && (c % 2 == 1)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < 4; i++) A_data[i*16 +: 16] = am[i][k];
                for (int j = 0; j < 4; j++) B_data[j*16 +: 16] = bm[k][j];
                k++;
            end
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run(input int n, input logic [1:0] d, input logic accm,
                       input bit stall_in, input bit stall_out, input string tag);
        logic [63:0] exp_row [4];
        int c, exp_lat;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (!accm) macc[i][j] = 0;
                for (int k = 0; k < n; k++)
                    macc[i][j] += longint'(am[i][k]) * longint'(bm[k][j]);
                exp_row[i][j*16 +: 16] = sat16(macc[i][j]);
            end
        start_run(n, d, accm, tag);
        feed(n, stall_in, c);
        while (!C_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        exp_lat = (stall_in ? 2 * n - 1 : n) + X + Y - 1;
        chk($sformatf("%s_latency", tag), 128'(c), 128'(exp_lat));
        for (int r = 0; r < 4; r++) begin
            if (stall_out && r == 1) begin
                C_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk($sformatf("%s_hold%0d", tag, s), {C_valid, C_row, C_data},
                        {1'b1, 2'd1, exp_row[1]});
                    @(negedge clk);
                end
                C_ready = 1'b1;
            end
            got[r] = C_data;
            chk($sformatf("%s_row%0d", tag, r), {C_valid, C_row, C_data},
                {1'b1, 2'(r), exp_row[r]});
            @(negedge clk);
        end
        chk($sformatf("%s_idle", tag), {busy, C_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b0; start = 1'b0; len = '0; dir = '0; accumulate = 1'b0;
        in_valid = 1'b0; A_data = '0; B_data = '0; C_ready = 1'b1;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) macc[i][j] = 0;
        repeat (2) @(negedge clk);
        chk("reset_vals", {in_ready, C_valid, C_data, C_row, busy, err}, '0);
        sys_rst = 1'b1;
        @(negedge clk);

        // Identity A: rows drain equal to B, first C_valid at cycle 11
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = (i == j) ? 16'sd1 : 16'sd0;
                bm[i][j] = 16'(i * 4 + j + 1);
            end
        run(4, 2'd0, 1'b0, 1'b0, 1'b0, "ident");
        chk("ident_hand_r0", got[0], {16'd4, 16'd3, 16'd2, 16'd1});
        chk("ident_hand_r3", got[3], {16'd16, 16'd15, 16'd14, 16'd13});

        // Signed operands under all four flow directions
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                am[i][k] = 16'((i * 5 - k * 3 + 1) * 7);
                bm[i][k] = 16'((i * 4 - k * 7 + 2) * 3);
            end
        for (int d = 0; d < 4; d++) begin
            run(4, 2'(d), 1'b0, 1'b0, 1'b0, $sformatf("dir%0d", d));
            for (int r = 0; r < 4; r++) begin
                if (d == 0) ref0[r] = got[r];
                else chk($sformatf("dir%0d_same_r%0d", d, r), got[r], ref0[r]);
            end
        end

        // Input bubbles every other FEED cycle and 3-cycle back-pressure on row 1
        run(4, 2'd1, 1'b0, 1'b1, 1'b1, "stall");
        for (int r = 0; r < 4; r++)
            chk($sformatf("stall_same_r%0d", r), got[r], ref0[r]);

        fill(32767, 32767);
        run(4, 2'd0, 1'b0, 1'b0, 1'b0, "satpos");
        chk("satpos_hand", got[2], {4{16'h7fff}});
        fill(-32768, 32767);
        run(4, 2'd3, 1'b0, 1'b0, 1'b0, "satneg");
        chk("satneg_hand", got[1], {4{16'h8000}});

        fill(1, 1);
        run(2, 2'd0, 1'b0, 1'b0, 1'b0, "acc1");
        chk("acc1_hand", got[0], {4{16'd2}});
        run(2, 2'd0, 1'b1, 1'b0, 1'b0, "acc2");
        chk("acc2_hand", got[3], {4{16'd4}});

        for (int b = 0; b < 2; b++) begin
            start = 1'b1; len = (b == 0) ? 3'd0 : 3'd5; accumulate = 1'b0;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("badlen%0d_err", b), {err, busy}, 2'b10);
            @(negedge clk);
            chk($sformatf("badlen%0d_clear", b), {err, busy}, 2'b00);
        end

        // Reset during FLUSH, then an accumulate run must start from zero
        fill(2, 2);
        start_run(4, 2'd0, 1'b0, "rst");
        feed(4, 1'b0, cyc);
        repeat (2) @(negedge clk);
        chk("rst_in_flush", {busy, C_valid, in_ready}, 3'b100);
        sys_rst = 1'b0;
        #1;
        chk("rst_midrun_vals", {in_ready, C_valid, C_data, C_row, busy, err}, '0);
        @(negedge clk);
        sys_rst = 1'b1;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) macc[i][j] = 0;
        @(negedge clk);
        fill(3, 3);
        run(1, 2'd0, 1'b1, 1'b0, 1'b0, "postrst");
        chk("postrst_hand", got[0], {4{16'd9}});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
